// File: rtl/smc_xfer_seq2.sv
// Static memory controller transfer sequencer.
// Splits each accepted AHB transfer into MEM_DW-wide external beats, each
// made of optional SETUP, STROBE and optional HOLD phases. The beat address,
// lane, strobes and done flags are decoded from registered state. Read data
// is assembled lane by lane into read_data.
module smc_xfer_seq2 #(
  parameter int MEM_DW   = 8,
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 2,
  parameter int T_HOLD   = 1
) (
  input  logic                hclk2,
  input  logic                n_sys_reset2,
  input  logic                new_access,
  input  logic [31:0]         addr,
  input  logic [1:0]          xfer_size,
  input  logic                n_read,
  input  logic [31:0]         write_data,
  input  logic [MEM_DW-1:0]   mem_rdata,
  output logic                smc_idle,
  output logic                smc_done,
  output logic                mac_done,
  output logic [31:0]         read_data,
  output logic [31:0]         mem_addr,
  output logic                mem_cs_n,
  output logic                mem_oe_n,
  output logic                mem_we_n,
  output logic [MEM_DW/8-1:0] mem_be_n,
  output logic [MEM_DW-1:0]   mem_wdata
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // A strobe length of 0 would leave no cycle to drive the strobe, so it
  // is stretched to 1.
  localparam int          STB_LEN   = (T_STROBE == 0) ? 1 : T_STROBE;
  localparam logic [3:0]  SET_LAST  = 4'((T_SETUP == 0) ? 0 : T_SETUP - 1);
  localparam logic [3:0]  STB_LAST  = 4'(STB_LEN - 1);
  localparam logic [3:0]  HLD_LAST  = 4'((T_HOLD == 0) ? 0 : T_HOLD - 1);
  localparam bit          NO_HOLD   = (T_HOLD == 0);
  localparam state_t      FIRST_PH  = (T_SETUP == 0) ? STROBE : SETUP;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic [31:0] read_data_q, read_data_d;

  logic [1:0]  last_k;
  logic [1:0]  lane8;
  logic [4:0]  lsb;
  logic        strobe_end;
  logic        beat_end;
  logic        xfer_end;
  logic        accept;

  // Index of the final beat for the registered transfer size.
  always_comb begin
    last_k = 2'd0;
    case (size_q)
      2'd0:    last_k = 2'd0;
      2'd1:    last_k = (MEM_DW == 8) ? 2'd1 : 2'd0;
      default: last_k = (MEM_DW == 8) ? 2'd3 : 2'd1;
    endcase
  end

  // Bit offset of the current beat's lane inside the 32-bit AHB word.
  always_comb begin
    lane8 = addr_q[1:0] + k_q;
    if (MEM_DW == 8) begin
      lsb = {lane8, 3'b000};
    end else begin
      lsb = {addr_q[1] ^ k_q[0], 4'b0000};
    end
  end

  assign strobe_end = (state_q == STROBE) && (cnt_q == STB_LAST);
  assign beat_end   = (strobe_end && NO_HOLD) ||
                      ((state_q == HOLD) && (cnt_q == HLD_LAST));
  assign xfer_end   = beat_end && (k_q == last_k);
  assign accept     = new_access && ((state_q == IDLE) || xfer_end);

  // Phase sequencing, beat stepping, read capture and transfer acceptance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wr_d        = wr_q;
    read_data_d = read_data_q;

    if (strobe_end && !wr_q) begin
      read_data_d[lsb +: MEM_DW] = mem_rdata;
    end

    case (state_q)
      SETUP: begin
        if (cnt_q == SET_LAST) begin
          state_d = STROBE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == STB_LAST) begin
          state_d = HOLD;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 4'd1;
      end
      default: begin
        cnt_d = 4'd0;
      end
    endcase

    // The last cycle of a beat either opens the next beat or ends the transfer.
    if (beat_end) begin
      cnt_d = 4'd0;
      if (k_q != last_k) begin
        k_d     = k_q + 2'd1;
        state_d = FIRST_PH;
      end else begin
        state_d = IDLE;
      end
    end

    // Acceptance overrides everything: a back-to-back access skips IDLE and
    // discards the previous transfer's read data.
    if (accept) begin
      addr_d      = addr;
      size_d      = xfer_size;
      wr_d        = n_read;
      k_d         = 2'd0;
      cnt_d       = 4'd0;
      read_data_d = 32'd0;
      state_d     = FIRST_PH;
    end
  end

  // State and datapath registers; reset drops any transfer in flight.
  always_ff @(posedge hclk2 or negedge n_sys_reset2) begin
    if (!n_sys_reset2) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      k_q         <= 2'd0;
      addr_q      <= 32'd0;
      size_q      <= 2'd0;
      wr_q        <= 1'b0;
      read_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wr_q        <= wr_d;
      read_data_q <= read_data_d;
    end
  end

  assign smc_idle  = (state_q == IDLE);
  assign smc_done  = beat_end;
  assign mac_done  = (state_q != IDLE) && (k_q == last_k);
  assign mem_cs_n  = (state_q == IDLE);
  assign mem_oe_n  = !((state_q == STROBE) && !wr_q);
  assign mem_we_n  = !((state_q == STROBE) && wr_q);
  assign read_data = read_data_q;
  assign mem_wdata = write_data[lsb +: MEM_DW];

  // A 16-bit bus steps in halfwords from an aligned base address.
  always_comb begin
    if (MEM_DW == 8) begin
      mem_addr = addr_q + {30'd0, k_q};
    end else begin
      mem_addr = {addr_q[31:1], 1'b0} + {29'd0, k_q, 1'b0};
    end
  end

  if (MEM_DW == 16) begin : g_be16
    // Byte accesses enable only the addressed half of the 16-bit bus.
    always_comb begin
      mem_be_n = 2'b11;
      if (state_q != IDLE) begin
        if (size_q == 2'd0) begin
          mem_be_n = addr_q[0] ? 2'b01 : 2'b10;
        end else begin
          mem_be_n = 2'b00;
        end
      end
    end
  end else begin : g_be8
    assign mem_be_n = {(MEM_DW/8){mem_cs_n}};
  end

endmodule

// File: tb/tb_smc_xfer_seq2.sv
// Directed bench for smc_xfer_seq2: three instances cover 8-bit 1/2/1,
// 16-bit 1/2/1 and 8-bit 0/1/0 timing. Expected beats are queued when a
// transfer is launched and checked as each beat completes.
module tb_smc_xfer_seq2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        na;
  logic [1:0]  sel;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        nrd;
  logic [15:0] rd;

  logic na8, na16, naf;
  assign na8  = na & (sel == 2'd0);
  assign na16 = na & (sel == 2'd1);
  assign naf  = na & (sel == 2'd2);

  logic        a_idle, a_done, a_mac, a_cs, a_oe, a_we;
  logic [31:0] a_rd, a_addr;
  logic [0:0]  a_be;
  logic [7:0]  a_wd;
  logic        b_idle, b_done, b_mac, b_cs, b_oe, b_we;
  logic [31:0] b_rd, b_addr;
  logic [1:0]  b_be;
  logic [15:0] b_wd;
  logic        c_idle, c_done, c_mac, c_cs, c_oe, c_we;
  logic [31:0] c_rd, c_addr;
  logic [0:0]  c_be;
  logic [7:0]  c_wd;

  smc_xfer_seq2 #(.MEM_DW(8), .T_SETUP(1), .T_STROBE(2), .T_HOLD(1)) u8 (
    .hclk2(clk), .n_sys_reset2(rst_n), .new_access(na8), .addr(addr),
    .xfer_size(size), .n_read(nrd), .write_data(wdata), .mem_rdata(rd[7:0]),
    .smc_idle(a_idle), .smc_done(a_done), .mac_done(a_mac), .read_data(a_rd),
    .mem_addr(a_addr), .mem_cs_n(a_cs), .mem_oe_n(a_oe), .mem_we_n(a_we),
    .mem_be_n(a_be), .mem_wdata(a_wd));

  smc_xfer_seq2 #(.MEM_DW(16), .T_SETUP(1), .T_STROBE(2), .T_HOLD(1)) u16 (
    .hclk2(clk), .n_sys_reset2(rst_n), .new_access(na16), .addr(addr),
    .xfer_size(size), .n_read(nrd), .write_data(wdata), .mem_rdata(rd),
    .smc_idle(b_idle), .smc_done(b_done), .mac_done(b_mac), .read_data(b_rd),
    .mem_addr(b_addr), .mem_cs_n(b_cs), .mem_oe_n(b_oe), .mem_we_n(b_we),
    .mem_be_n(b_be), .mem_wdata(b_wd));

  smc_xfer_seq2 #(.MEM_DW(8), .T_SETUP(0), .T_STROBE(1), .T_HOLD(0)) uf (
    .hclk2(clk), .n_sys_reset2(rst_n), .new_access(naf), .addr(addr),
    .xfer_size(size), .n_read(nrd), .write_data(wdata), .mem_rdata(rd[7:0]),
    .smc_idle(c_idle), .smc_done(c_done), .mac_done(c_mac), .read_data(c_rd),
    .mem_addr(c_addr), .mem_cs_n(c_cs), .mem_oe_n(c_oe), .mem_we_n(c_we),
    .mem_be_n(c_be), .mem_wdata(c_wd));

  // Observation mux onto the instance under test.
  logic        o_idle, o_done, o_mac, o_cs, o_oe, o_we;
  logic [31:0] o_rd, o_addr, o_wd;
  logic [1:0]  o_be;
  always_comb begin
    case (sel)
      2'd1: begin
        o_idle = b_idle; o_done = b_done; o_mac = b_mac; o_cs = b_cs;
        o_oe = b_oe; o_we = b_we; o_rd = b_rd; o_addr = b_addr;
        o_wd = {16'd0, b_wd}; o_be = b_be;
      end
      2'd2: begin
        o_idle = c_idle; o_done = c_done; o_mac = c_mac; o_cs = c_cs;
        o_oe = c_oe; o_we = c_we; o_rd = c_rd; o_addr = c_addr;
        o_wd = {24'd0, c_wd}; o_be = {1'b0, c_be};
      end
      default: begin
        o_idle = a_idle; o_done = a_done; o_mac = a_mac; o_cs = a_cs;
        o_oe = a_oe; o_we = a_we; o_rd = a_rd; o_addr = a_addr;
        o_wd = {24'd0, a_wd}; o_be = {1'b0, a_be};
      end
    endcase
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] wd;
    logic        wr;
  } exp_t;

  exp_t        q_exp[$];
  logic [15:0] q_rd[$];

  logic        s_idle[64], s_cs[64], s_done[64], s_mac[64], s_we[64], s_oe[64];
  logic [31:0] s_addr[64], s_rd[64], s_wd[64];
  logic [1:0]  s_be[64];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected beats of one transfer, derived from address, size and bus width.
  task automatic push_beats(input logic [31:0] a, input logic [1:0] sz,
                            input logic wr, input logic [31:0] wd, input int dw);
    int nb;
    int lane;
    exp_t e;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? ((dw == 8) ? 2 : 1) : ((dw == 8) ? 4 : 2);
    for (int k = 0; k < nb; k++) begin
      if (dw == 8) begin
        e.a  = a + 32'(k);
        lane = (int'(a[1:0]) + k) % 4;
        e.wd = (wd >> (8 * lane)) & 32'h0000_00FF;
      end else begin
        e.a  = (a & ~32'h1) + 32'(2 * k);
        lane = (int'(a[1]) + k) % 2;
        e.wd = (wd >> (16 * lane)) & 32'h0000_FFFF;
      end
      e.wr = wr;
      q_exp.push_back(e);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [1:0] sz,
                       input logic nr, input logic [31:0] wd);
    addr  = a;
    size  = sz;
    nrd   = nr;
    wdata = wd;
    na    = 1'b1;
  endtask

  // Runs ncyc cycles after the launching edge, recording outputs and checking
  // each completed beat; an optional second access is raised at cycle b2b_c.
  task automatic run(input int ncyc, input int b2b_c, input logic [31:0] nx_a,
                     input logic [1:0] nx_sz, input logic nx_nr, input logic [31:0] nx_wd,
                     input int nx_dw);
    exp_t e;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) na = 1'b0;
      s_idle[c] = o_idle; s_cs[c] = o_cs; s_done[c] = o_done; s_mac[c] = o_mac;
      s_we[c] = o_we; s_oe[c] = o_oe; s_addr[c] = o_addr; s_rd[c] = o_rd;
      s_wd[c] = o_wd; s_be[c] = o_be;
      rd = (q_rd.size() > 0) ? q_rd[0] : 16'h0;
      if (o_done === 1'b1) begin
        if (q_exp.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL sb_underflow: unexpected beat at cycle %0d addr %h", c, o_addr);
        end else begin
          e = q_exp.pop_front();
          chk($sformatf("sb_addr_c%0d", c), o_addr, e.a);
          if (e.wr) chk($sformatf("sb_wdata_c%0d", c), o_wd, e.wd);
          else if (q_rd.size() > 0) void'(q_rd.pop_front());
        end
      end
      if (c == b2b_c) begin
        start(nx_a, nx_sz, nx_nr, nx_wd);
        push_beats(nx_a, nx_sz, nx_nr, nx_wd, nx_dw);
      end else if (c == b2b_c + 1) begin
        na = 1'b0;
      end
    end
  endtask

  int cnt_a, cnt_b, cnt_c;

  initial begin
    rst_n = 1'b0; na = 1'b0; sel = 2'd0; addr = '0; size = '0; nrd = 1'b0;
    wdata = '0; rd = '0;
    repeat (2) @(negedge clk);

    // Reset values.
    chk("rst_idle", o_idle, 1);
    chk("rst_done", o_done, 0);
    chk("rst_mac", o_mac, 0);
    chk("rst_rdata", o_rd, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_cs", o_cs, 1);
    chk("rst_oe", o_oe, 1);
    chk("rst_we", o_we, 1);
    chk("rst_be8", o_be, 2'b01);
    sel = 2'd1;
    #1;
    chk("rst_be16", o_be, 2'b11);
    sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word read at 0x100 on the 8-bit bus, four beats of 1/2/1.
    q_rd.push_back(16'h11); q_rd.push_back(16'h22);
    q_rd.push_back(16'h33); q_rd.push_back(16'h44);
    push_beats(32'h100, 2'd2, 1'b0, 32'h0, 8);
    start(32'h100, 2'd2, 1'b0, 32'h0);
    run(18, 0, 32'h0, 2'd0, 1'b0, 32'h0, 8);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int c = 1; c <= 18; c++) begin
      chk($sformatf("t1_mac_c%0d", c), s_mac[c], (c >= 13 && c <= 16) ? 1 : 0);
      if (s_cs[c] === 1'b0) cnt_a++;
      if (s_done[c] === 1'b1) cnt_b++;
      if (s_oe[c] === 1'b0) cnt_c++;
    end
    chk("t1_busy", cnt_a, 16);
    chk("t1_done_cnt", cnt_b, 4);
    chk("t1_oe_cnt", cnt_c, 8);
    chk("t1_rdata", s_rd[17], 32'h4433_2211);
    chk("t1_idle_after", s_idle[17], 1);

    // Byte write at 0x203: lane 3 of write_data, single beat.
    push_beats(32'h203, 2'd0, 1'b1, 32'hAB00_0000, 8);
    start(32'h203, 2'd0, 1'b1, 32'hAB00_0000);
    run(6, 0, 32'h0, 2'd0, 1'b0, 32'h0, 8);
    cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 6; c++) begin
      if (s_we[c] === 1'b0) cnt_a++;
      if (s_mac[c] === 1'b1) cnt_b++;
    end
    chk("t2_we_cnt", cnt_a, 2);
    chk("t2_mac_cnt", cnt_b, 4);
    chk("t2_wdata", s_wd[2], 32'hAB);
    chk("t2_idle_after", s_idle[5], 1);

    // Byte read at 0x10, then a byte write to 0x20 raised in its final cycle.
    q_rd.push_back(16'h5A);
    push_beats(32'h10, 2'd0, 1'b0, 32'h0, 8);
    start(32'h10, 2'd0, 1'b0, 32'h0);
    run(9, 4, 32'h20, 2'd0, 1'b1, 32'h0000_00C3, 8);
    cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 8; c++) begin
      if (s_idle[c] === 1'b1) cnt_a++;
      if (s_mac[c] === 1'b1) cnt_b++;
    end
    chk("t3_idle_cnt", cnt_a, 0);
    chk("t3_mac_cnt", cnt_b, 8);
    chk("t3_rdata_first", s_rd[4], 32'h5A);
    chk("t3_rdata_cleared", s_rd[5], 0);
    chk("t3_next_addr", s_addr[5], 32'h20);
    chk("t3_next_cs", s_cs[5], 0);
    chk("t3_next_we_setup", s_we[5], 1);
    chk("t3_idle_end", s_idle[9], 1);

    // 16-bit bus: half read at 0x2 lands in the upper half of read_data.
    sel = 2'd1;
    q_rd.push_back(16'hBEEF);
    push_beats(32'h2, 2'd1, 1'b0, 32'h0, 16);
    start(32'h2, 2'd1, 1'b0, 32'h0);
    run(5, 0, 32'h0, 2'd0, 1'b0, 32'h0, 16);
    chk("t4_addr", s_addr[2], 32'h2);
    chk("t4_be_half", s_be[2], 2'b00);
    chk("t4_rdata", s_rd[5], 32'hBEEF_0000);

    // 16-bit bus: byte writes at odd and even addresses.
    push_beats(32'h3, 2'd0, 1'b1, 32'h1234_5678, 16);
    start(32'h3, 2'd0, 1'b1, 32'h1234_5678);
    run(5, 0, 32'h0, 2'd0, 1'b0, 32'h0, 16);
    chk("t4_be_odd", s_be[2], 2'b01);
    chk("t4_wd_odd", s_wd[2], 32'h1234);
    chk("t4_we_odd", s_we[2], 0);
    push_beats(32'h0, 2'd0, 1'b1, 32'h1234_5678, 16);
    start(32'h0, 2'd0, 1'b1, 32'h1234_5678);
    run(5, 0, 32'h0, 2'd0, 1'b0, 32'h0, 16);
    chk("t4_be_even", s_be[2], 2'b10);
    chk("t4_wd_even", s_wd[2], 32'h5678);

    // 0/1/0 timing: four single-cycle beats, address wrapping past 2^32.
    sel = 2'd2;
    push_beats(32'hFFFF_FFFE, 2'd2, 1'b1, 32'hDDCC_BBAA, 8);
    start(32'hFFFF_FFFE, 2'd2, 1'b1, 32'hDDCC_BBAA);
    run(6, 0, 32'h0, 2'd0, 1'b0, 32'h0, 8);
    cnt_a = 0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("t5_done_c%0d", c), s_done[c], (c <= 4) ? 1 : 0);
      chk($sformatf("t5_mac_c%0d", c), s_mac[c], (c == 4) ? 1 : 0);
      if (s_cs[c] === 1'b0) cnt_a++;
    end
    chk("t5_cs_cnt", cnt_a, 4);
    chk("t5_idle_after", s_idle[5], 1);

    // Reset asserted during the second beat's strobe of a word read.
    sel = 2'd0;
    q_rd.push_back(16'h11); q_rd.push_back(16'h22);
    q_rd.push_back(16'h33); q_rd.push_back(16'h44);
    push_beats(32'h100, 2'd0, 1'b0, 32'h0, 8);
    start(32'h100, 2'd2, 1'b0, 32'h0);
    run(6, 0, 32'h0, 2'd0, 1'b0, 32'h0, 8);
    chk("t6_partial_rdata", s_rd[6], 32'h11);
    chk("t6_oe_strobe", s_oe[6], 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cs", o_cs, 1);
    chk("t6_rst_oe", o_oe, 1);
    chk("t6_rst_idle", o_idle, 1);
    chk("t6_rst_rdata", o_rd, 0);
    q_rd.delete();
    rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q_rd.push_back(16'h77);
    push_beats(32'h42, 2'd0, 1'b0, 32'h0, 8);
    start(32'h42, 2'd0, 1'b0, 32'h0);
    run(6, 0, 32'h0, 2'd0, 1'b0, 32'h0, 8);
    chk("t6_after_addr", s_addr[2], 32'h42);
    chk("t6_after_rdata", s_rd[5], 32'h0077_0000);

    chk("sb_leftover", 32'(q_exp.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
